// File: rtl/kalman_pkg.sv
// Shared types and helpers for the filter arbiter: FSM state encoding,
// default datapath width and a width helper for index ports.
package kalman_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DW_DEF = 8;

  // Index width with a floor of one bit, so single-entry ranges still get a port.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping modulo N_CH.
module rr_arbiter
  import kalman_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  int          w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = int'(rr_ptr) + i;
      if (w_sum >= N_CH) w_sum = w_sum - N_CH;
      w_idx = IW'(w_sum);
      if (!grant_any && req[w_idx]) begin
        grant_any = 1'b1;
        grant_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/kalman_arbiter.sv
// Time-shares one kalman_filter among N_CH sensor channels: round-robin grant,
// one-cycle valid to the filter, bounded wait for ready, tagged result or timeout.
module kalman_arbiter
  import kalman_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*DW-1:0]         sample_flat,
  output logic [N_CH-1:0]            ack,
  output logic                       kf_valid,
  output logic [DW-1:0]              kf_measurement,
  input  logic [DW-1:0]              kf_filtered,
  input  logic                       kf_ready,
  output logic                       res_valid,
  output logic [clog2(N_CH)-1:0]     res_ch,
  output logic [DW-1:0]              res_data,
  output logic                       timeout_err
);

  localparam int IW = clog2(N_CH);
  localparam int CW = clog2(TIMEOUT);

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_grant, w_grant_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [N_CH-1:0] r_ack, w_ack_nxt;
  logic            r_kf_valid, w_kf_valid_nxt;
  logic [DW-1:0]   r_meas, w_meas_nxt;
  logic            r_res_valid, w_res_valid_nxt;
  logic [IW-1:0]   r_res_ch, w_res_ch_nxt;
  logic [DW-1:0]   r_res_data, w_res_data_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [IW-1:0]   w_grant_idx;
  logic            w_grant_any;
  logic [DW-1:0]   w_sample;
  logic [N_CH-1:0] w_onehot;

  function automatic logic [IW-1:0] next_ch(input logic [IW-1:0] g);
    return (g == IW'(N_CH - 1)) ? '0 : g + IW'(1);
  endfunction

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_rr (
    .req       (req),
    .rr_ptr    (r_ptr),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign w_sample = sample_flat[w_grant_idx*DW +: DW];
  assign w_onehot = N_CH'(1) << w_grant_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_kf_valid  <= 1'b0;
      r_meas      <= '0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_kf_valid  <= w_kf_valid_nxt;
      r_meas      <= w_meas_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_ch    <= w_res_ch_nxt;
      r_res_data  <= w_res_data_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Every output is a register; this block computes their next values, so pulses
  // are set on the edge that enters the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = '0;
    w_kf_valid_nxt  = 1'b0;
    w_meas_nxt      = r_meas;
    w_res_valid_nxt = 1'b0;
    w_res_ch_nxt    = r_res_ch;
    w_res_data_nxt  = r_res_data;
    w_timeout_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt    = ST_ISSUE;
          w_grant_nxt    = w_grant_idx;
          w_meas_nxt     = w_sample;
          w_ack_nxt      = w_onehot;
          w_kf_valid_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // Ready takes precedence over an expiring counter in the same cycle.
        if (kf_ready) begin
          w_state_nxt     = ST_DONE;
          w_res_data_nxt  = kf_filtered;
          w_res_ch_nxt    = r_grant;
          w_res_valid_nxt = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_res_ch_nxt  = r_grant;
          w_timeout_nxt = 1'b1;
          w_ptr_nxt     = next_ch(r_grant);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = next_ch(r_grant);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack            = r_ack;
  assign kf_valid       = r_kf_valid;
  assign kf_measurement = r_meas;
  assign res_valid      = r_res_valid;
  assign res_ch         = r_res_ch;
  assign res_data       = r_res_data;
  assign timeout_err    = r_timeout;

endmodule

// File: doc/kalman_arbiter.md
# kalman_arbiter

- Time-shares one `kalman_filter` datapath among `N_CH` sensor channels.
- Each cycle it is free, it picks one pending channel by round-robin and captures that channel's sample.
- It drives the filter's one-cycle `valid` pulse and waits for `ready`, then returns `filtered_out` tagged with the channel index.
- It sits between the sensor front-ends and the filter instance and flags filters that never respond.

## Interface
Parameters:
- `N_CH`, 4, number of requesting channels (2..16)
- `DW`, 8, sample/result width, matches filter datapath
- `TIMEOUT`, 64, max cycles waited for `kf_ready` before abort (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `req`  in  N_CH  per-channel request level; held until `ack` bit seen
- `sample_flat`  in  N_CH*DW  channel c sample at bits [c*DW +: DW]
- `ack`  out  N_CH  one-hot, one-cycle pulse: channel's sample captured
- `kf_valid`  out  1  to filter `valid`; one-cycle pulse
- `kf_measurement`  out  DW  to filter `measurement`; held stable from issue until next issue
- `kf_filtered`  in  DW  from filter `filtered_out`
- `kf_ready`  in  1  from filter `ready`
- `res_valid`  out  1  one-cycle pulse, result available
- `res_ch`  out  $clog2(N_CH)  channel index of result or timeout
- `res_data`  out  DW  filtered value
- `timeout_err`  out  1  one-cycle pulse, filter did not answer

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `req` != 0, grant the first set bit at or after `rr_ptr`, wrapping modulo N_CH.
  - Latch grant index and its sample; go ISSUE.
  - `req` == 0: stay.
- ISSUE (exactly 1 cycle): `kf_valid`=1, `ack[grant]`=1, `kf_measurement`=latched sample; go WAIT; clear wait counter.
- WAIT: `kf_ready` sampled only here, never in the ISSUE cycle.
  - `kf_ready`=1: latch `kf_filtered` into `res_data`; go DONE.
  - Else the counter increments. At count == TIMEOUT-1 without ready: pulse `timeout_err` with `res_ch`=grant, set `rr_ptr`=grant+1 (wrapping), go IDLE.
- DONE (1 cycle): `res_valid`=1, `res_ch`=grant; `rr_ptr`=grant+1 wrapping; go IDLE.
- Fairness: the granted channel becomes lowest priority. A channel with `req` held continuously is served within N_CH grants.
- Channel whose `req` drops before grant: not served, no `ack`.
- Simultaneous `kf_ready` and counter == TIMEOUT-1: ready wins, no `timeout_err`.
- Reset (`rst`=0 at any edge, including mid-WAIT): state IDLE, `rr_ptr`=0, counter 0. Every output 0: `ack`, `kf_valid`, `kf_measurement`, `res_valid`, `res_ch`, `res_data`, `timeout_err`.

## Timing
- All outputs registered.
- `req` seen in IDLE at cycle T → `ack`/`kf_valid` high in T+1.
- `kf_ready` first high in WAIT cycle R → `res_valid`/`res_data` in R+1, IDLE in R+2.
- Minimum service interval: 4 cycles per sample (ISSUE, WAIT, DONE, IDLE).
- Timeout abort: `timeout_err` high TIMEOUT+1 cycles after the ISSUE cycle. Back in IDLE the following cycle.
- `res_data`/`res_ch` hold their value until the next DONE or timeout.

## Structure
- Shared package `kalman_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - default `DW`
  - `clog2` helper for `res_ch` width
- Sub-module `rr_arbiter`: combinational, inputs `req`/`rr_ptr`, outputs `grant_idx`/`grant_any`. The FSM, counter and registers stay in `kalman_arbiter`.

## Test plan
- Single channel: `req`=0b0100, sample[2]=8'd55; filter model asserts ready 3 cycles after valid, `filtered_out`=8'd52 → `ack`=0b0100 and `kf_measurement`=55 in T+1; `res_valid` with `res_ch`=2, `res_data`=52 one cycle after ready.
- Round-robin: `req`=0b1111 held, re-asserted after each ack → grant order 0,1,2,3,0; each channel's sample appears on `kf_measurement` exactly once per round.
- Timeout: TIMEOUT=8, filter never ready → `timeout_err` pulses 9 cycles after ISSUE with `res_ch` = grant; no `res_valid`; next grant goes to grant+1.
- Ready/timeout collision: `kf_ready`=1 exactly at counter 7 (TIMEOUT=8) → `res_valid`=1, `timeout_err`=0.
- Reset mid-WAIT: `rst`=0 for 1 cycle during WAIT → all outputs 0 next cycle; `rr_ptr`=0; a later ready from the filter in IDLE is ignored, no `res_valid`.
- Back-to-back stream: 50 samples on ch0 (values 50..99, filter model adds +1, ready after 2 cycles) → 50 `res_valid` pulses with `res_data` 51..100 in order, interval 5 cycles.
